axi_llc_way_xbar: RTL and testbench

Parametrised request/response interconnect between LLC units and data ways. Any number of units and ways are supported, and any subset of units can receive read responses. Each read-capable unit has its own order FIFO, so responses return in request order per unit even when ways answer out of order. The block sits between the LLC units (evict, refill, W, R and future units) and the external data-way macros.

---
 rtl/axi_llc_way_xbar.sv | 251 +++++++++++++++++++++++++
 tb/tb_axi_llc_way_xbar.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_llc_way_xbar.sv
// Request/response crossbar between LLC units and data ways: one round-robin
// arbiter per way, one in-order response FIFO per read-capable unit.

module axi_llc_way_arb #(
    parameter int NumUnits = 4,
    parameter int UW       = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumUnits-1:0] req,
    input  logic                ready,
    output logic                valid,
    output logic [UW-1:0]       gnt
);
    logic [UW-1:0] ptr_q, lock_unit_q;
    logic          lock_q;
    logic          found;

    // A stalled grant is pinned to its unit so payload/unit stay stable.
    always_comb begin
        valid = 1'b0;
        gnt   = '0;
        found = 1'b0;
        if (lock_q && req[lock_unit_q]) begin
            valid = 1'b1;
            gnt   = lock_unit_q;
        end else begin
            for (int i = 0; i < NumUnits; i++) begin
                if (!found && req[(int'(ptr_q) + i) % NumUnits]) begin
                    found = 1'b1;
                    gnt   = UW'((int'(ptr_q) + i) % NumUnits);
                end
            end
            valid = found;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            lock_q      <= 1'b0;
            lock_unit_q <= '0;
        end else if (valid && ready) begin
            lock_q <= 1'b0;
            ptr_q  <= UW'((int'(gnt) + 1) % NumUnits);
        end else if (valid) begin
            lock_q      <= 1'b1;
            lock_unit_q <= gnt;
        end
    end
endmodule

module axi_llc_ord_fifo #(
    parameter int Depth = 2,
    parameter int WW    = 1,
    parameter int CW    = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [WW-1:0] data_i,
    input  logic          pop_i,
    output logic [WW-1:0] head_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = $clog2(Depth);

    logic [WW-1:0] mem [Depth];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_q] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= nxt(wr_q);
            if (pop_i)  rd_q <= nxt(rd_q);
            if (push_i && !pop_i)      cnt_q <= cnt_q + CW'(1);
            else if (pop_i && !push_i) cnt_q <= cnt_q - CW'(1);
        end
    end

    // Head is read from storage, so a pushed entry shows up one cycle later.
    assign head_o  = mem[rd_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(Depth));
    assign count_o = cnt_q;
endmodule

module axi_llc_way_xbar #(
    parameter int                  NumUnits  = 4,
    parameter int                  NumWays   = 8,
    parameter logic [NumUnits-1:0] ReadUnits = NumUnits'(4'b1001),
    parameter int                  OrdDepth  = NumWays + 1,
    parameter int                  ReqWidth  = 64,
    parameter int                  RspWidth  = 64,
    localparam int                 UW = (NumUnits > 1) ? $clog2(NumUnits) : 1,
    localparam int                 WW = (NumWays > 1) ? $clog2(NumWays) : 1,
    localparam int                 CW = $clog2(OrdDepth + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumUnits-1:0][ReqWidth-1:0]  req_data_i,
    input  logic [NumUnits-1:0][NumWays-1:0]   req_way_i,
    input  logic [NumUnits-1:0]                req_valid_i,
    output logic [NumUnits-1:0]                req_ready_o,
    output logic [NumWays-1:0][ReqWidth-1:0]   way_req_data_o,
    output logic [NumWays-1:0][UW-1:0]         way_req_unit_o,
    output logic [NumWays-1:0]                 way_req_valid_o,
    input  logic [NumWays-1:0]                 way_req_ready_i,
    input  logic [NumWays-1:0][RspWidth-1:0]   way_rsp_data_i,
    input  logic [NumWays-1:0][UW-1:0]         way_rsp_unit_i,
    input  logic [NumWays-1:0]                 way_rsp_valid_i,
    output logic [NumWays-1:0]                 way_rsp_ready_o,
    output logic [NumUnits-1:0][RspWidth-1:0]  rsp_data_o,
    output logic [NumUnits-1:0]                rsp_valid_o,
    input  logic [NumUnits-1:0]                rsp_ready_i,
    output logic [NumUnits-1:0][CW-1:0]        outstanding_o,
    output logic                               err_o,
    output logic [UW-1:0]                      err_unit_o
);
    logic [NumUnits-1:0]               one_hot, malformed, elig;
    logic [NumUnits-1:0][WW-1:0]       way_idx;
    logic [NumWays-1:0][NumUnits-1:0]  way_reqs;
    logic [NumWays-1:0]                gnt_vld;
    logic [NumWays-1:0][UW-1:0]        gnt_unit;
    logic [NumUnits-1:0]               req_ready, push, pop, rsp_valid;
    logic [NumWays-1:0]                way_rsp_ready;
    logic [NumUnits-1:0]               fifo_empty, fifo_full;
    logic [NumUnits-1:0][WW-1:0]       head_way;
    logic                              err_n;
    logic [UW-1:0]                     err_unit_n;
    logic                              err_q;
    logic [UW-1:0]                     err_unit_q;

    // Decode, eligibility and per-way request vectors.
    always_comb begin
        way_idx  = '0;
        way_reqs = '0;
        for (int u = 0; u < NumUnits; u++) begin
            one_hot[u]   = $onehot(req_way_i[u]);
            malformed[u] = req_valid_i[u] & ~one_hot[u];
            elig[u]      = req_valid_i[u] & one_hot[u] & ~(ReadUnits[u] & fifo_full[u]);
            for (int w = 0; w < NumWays; w++) begin
                if (req_way_i[u][w]) way_idx[u] = way_idx[u] | WW'(w);
                way_reqs[w][u] = elig[u] & req_way_i[u][w];
            end
        end
    end

    for (genvar w = 0; w < NumWays; w++) begin : g_way
        axi_llc_way_arb #(.NumUnits(NumUnits), .UW(UW)) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .req   (way_reqs[w]),
            .ready (way_req_ready_i[w]),
            .valid (gnt_vld[w]),
            .gnt   (gnt_unit[w])
        );
        assign way_req_data_o[w]  = req_data_i[gnt_unit[w]];
        assign way_req_unit_o[w]  = gnt_unit[w];
        assign way_req_valid_o[w] = gnt_vld[w] & ~rst_i;
    end

    // Malformed requests are swallowed immediately; good ones wait for their way.
    always_comb begin
        for (int u = 0; u < NumUnits; u++) begin
            req_ready[u] = malformed[u];
            for (int w = 0; w < NumWays; w++) begin
                if (gnt_vld[w] && gnt_unit[w] == UW'(u) && way_req_ready_i[w])
                    req_ready[u] = 1'b1;
            end
            push[u] = req_ready[u] & one_hot[u] & ~rst_i;
        end
    end

    for (genvar u = 0; u < NumUnits; u++) begin : g_unit
        if (ReadUnits[u]) begin : g_rd
            axi_llc_ord_fifo #(.Depth(OrdDepth), .WW(WW), .CW(CW)) u_fifo (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .push_i  (push[u]),
                .data_i  (way_idx[u]),
                .pop_i   (pop[u]),
                .head_o  (head_way[u]),
                .empty_o (fifo_empty[u]),
                .full_o  (fifo_full[u]),
                .count_o (outstanding_o[u])
            );
        end else begin : g_wr
            assign head_way[u]      = '0;
            assign fifo_empty[u]    = 1'b1;
            assign fifo_full[u]     = 1'b0;
            assign outstanding_o[u] = '0;
        end
    end

    // A way response only moves when the unit whose FIFO head points at it is tagged.
    always_comb begin
        rsp_valid     = '0;
        way_rsp_ready = '0;
        rsp_data_o    = '0;
        for (int u = 0; u < NumUnits; u++) begin
            if (!fifo_empty[u]) begin
                rsp_data_o[u] = way_rsp_data_i[head_way[u]];
                if (way_rsp_unit_i[head_way[u]] == UW'(u)) begin
                    rsp_valid[u] = way_rsp_valid_i[head_way[u]];
                    if (rsp_ready_i[u]) way_rsp_ready[head_way[u]] = 1'b1;
                end
            end
        end
    end

    assign pop             = rsp_valid & rsp_ready_i & {NumUnits{~rst_i}};
    assign rsp_valid_o     = rst_i ? '0 : rsp_valid;
    assign way_rsp_ready_o = rst_i ? '0 : way_rsp_ready;
    assign req_ready_o     = rst_i ? '0 : req_ready;

    always_comb begin
        err_n      = |malformed;
        err_unit_n = '0;
        for (int u = NumUnits - 1; u >= 0; u--) begin
            if (malformed[u]) err_unit_n = UW'(u);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q      <= 1'b0;
            err_unit_q <= '0;
        end else begin
            err_q      <= err_n;
            err_unit_q <= err_unit_n;
        end
    end

    assign err_o      = err_q;
    assign err_unit_o = err_unit_q;
endmodule

// File: tb/tb_axi_llc_way_xbar.sv
// Directed bench for axi_llc_way_xbar at default parameters (4 units, 8 ways,
// read units 0 and 3, order depth 9).

module tb_axi_llc_way_xbar;
    localparam int NU = 4, NW = 8, DW = 64, UW = 2, CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NU-1:0][DW-1:0] req_data;
    logic [NU-1:0][NW-1:0] req_way;
    logic [NU-1:0]         req_valid, req_ready;
    logic [NW-1:0][DW-1:0] way_req_data;
    logic [NW-1:0][UW-1:0] way_req_unit;
    logic [NW-1:0]         way_req_valid, way_req_ready;
    logic [NW-1:0][DW-1:0] way_rsp_data;
    logic [NW-1:0][UW-1:0] way_rsp_unit;
    logic [NW-1:0]         way_rsp_valid, way_rsp_ready;
    logic [NU-1:0][DW-1:0] rsp_data;
    logic [NU-1:0]         rsp_valid, rsp_ready;
    logic [NU-1:0][CW-1:0] outstanding;
    logic                  err;
    logic [UW-1:0]         err_unit;

    int checks = 0;
    int failures = 0;

    axi_llc_way_xbar dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_data_i      (req_data),
        .req_way_i       (req_way),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .way_req_data_o  (way_req_data),
        .way_req_unit_o  (way_req_unit),
        .way_req_valid_o (way_req_valid),
        .way_req_ready_i (way_req_ready),
        .way_rsp_data_i  (way_rsp_data),
        .way_rsp_unit_i  (way_rsp_unit),
        .way_rsp_valid_i (way_rsp_valid),
        .way_rsp_ready_o (way_rsp_ready),
        .rsp_data_o      (rsp_data),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .outstanding_o   (outstanding),
        .err_o           (err),
        .err_unit_o      (err_unit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        req_data      = '0;
        req_way       = '0;
        req_valid     = '0;
        way_req_ready = '0;
        way_rsp_data  = '0;
        way_rsp_unit  = '0;
        way_rsp_valid = '0;
        rsp_ready     = '0;
    endtask

    int exp_seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        clear_in();
        rst = 1'b1;
        tick();
        // Outputs held low while in reset, even with live stimulus.
        req_valid[0] = 1'b1; req_way[0] = 8'h01; way_req_ready = '1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_way_valid", way_req_valid, 0);
        tick();
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err, 0);
        clear_in();
        rst = 1'b0;
        tick();

        // Basic read: unit 0 -> way 3.
        req_data[0] = 64'hA5; req_way[0] = 8'b0000_1000; req_valid[0] = 1'b1;
        way_req_ready[3] = 1'b1;
        #1;
        chk("t1_req_ready", req_ready[0], 1);
        chk("t1_way_valid", way_req_valid, 8'b0000_1000);
        chk("t1_way_unit", way_req_unit[3], 0);
        chk("t1_way_data", way_req_data[3], 64'hA5);
        tick();
        clear_in();
        chk("t1_outst_1", outstanding[0], 1);
        tick();
        way_rsp_valid[3] = 1'b1; way_rsp_unit[3] = 2'd0; way_rsp_data[3] = 64'h5A5A;
        rsp_ready = '1;
        #1;
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rsp_data", rsp_data[0], 64'h5A5A);
        chk("t1_way_rsp_ready", way_rsp_ready, 8'b0000_1000);
        tick();
        clear_in();
        chk("t1_outst_0", outstanding[0], 0);

        // Out-of-order ways: unit 3 -> way 5, then way 2; way 2 answers first.
        way_req_ready = '1;
        req_valid[3] = 1'b1; req_way[3] = 8'b0010_0000;
        tick();
        req_way[3] = 8'b0000_0100;
        tick();
        clear_in();
        chk("t2_outst", outstanding[3], 2);
        way_rsp_valid[2] = 1'b1; way_rsp_unit[2] = 2'd3; way_rsp_data[2] = 64'h22;
        rsp_ready = '1;
        #1;
        chk("t2_stall_valid", rsp_valid[3], 0);
        chk("t2_stall_ready", way_rsp_ready[2], 0);
        tick();
        chk("t2_stall_ready2", way_rsp_ready[2], 0);
        way_rsp_valid[5] = 1'b1; way_rsp_unit[5] = 2'd3; way_rsp_data[5] = 64'h55;
        #1;
        chk("t2_w5_valid", rsp_valid[3], 1);
        chk("t2_w5_data", rsp_data[3], 64'h55);
        chk("t2_w5_ready", way_rsp_ready, 8'b0010_0000);
        tick();
        way_rsp_valid[5] = 1'b0;
        #1;
        chk("t2_w2_valid", rsp_valid[3], 1);
        chk("t2_w2_data", rsp_data[3], 64'h22);
        chk("t2_w2_ready", way_rsp_ready, 8'b0000_0100);
        tick();
        clear_in();
        chk("t2_outst_0", outstanding[3], 0);

        // Round robin on way 1 with all units requesting.
        for (int u = 0; u < NU; u++) begin
            req_data[u] = 64'h100 + 64'(u);
            req_way[u]  = 8'b0000_0010;
        end
        req_valid = 4'b1111;
        way_req_ready[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_unit", way_req_unit[1], 64'(exp_seq[i]));
            chk("rr_ready", req_ready, 64'(4'b0001 << exp_seq[i]));
            tick();
        end
        // Pointer now at 1; only unit 3 asks, stalls, and must keep the grant.
        req_valid = 4'b1000;
        way_req_ready[1] = 1'b0;
        #1;
        chk("lock_unit0", way_req_unit[1], 3);
        chk("lock_ready0", req_ready, 0);
        tick();
        req_valid = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lock_unit", way_req_unit[1], 3);
            chk("lock_data", way_req_data[1], 64'h103);
            chk("lock_ready", req_ready, 0);
            tick();
        end
        way_req_ready[1] = 1'b1;
        #1;
        chk("lock_release", req_ready, 4'b1000);
        tick();
        clear_in();
        chk("rr_outst0", outstanding[0], 2);
        chk("rr_outst1", outstanding[1], 0);
        chk("rr_outst3", outstanding[3], 2);
        // Drain the way-1 entries of units 0 and 3.
        way_rsp_valid[1] = 1'b1; rsp_ready = '1;
        way_rsp_unit[1] = 2'd0;
        tick(); tick();
        way_rsp_unit[1] = 2'd3;
        tick(); tick();
        clear_in();
        chk("rr_drained", outstanding, 0);

        // Fill unit 0's order FIFO to its depth of 9.
        req_way[0] = 8'h01; req_valid[0] = 1'b1; way_req_ready = '1;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("fill_ready", req_ready[0], 1);
            tick();
        end
        chk("full_outst", outstanding[0], 9);
        chk("full_ready", req_ready[0], 0);
        chk("full_way_valid", way_req_valid[0], 0);
        way_rsp_valid[0] = 1'b1; way_rsp_unit[0] = 2'd0; rsp_ready[0] = 1'b1;
        #1;
        chk("full_pop_valid", rsp_valid[0], 1);
        chk("full_pop_ready", req_ready[0], 0);
        tick();
        chk("full_after_pop", outstanding[0], 8);
        chk("pushpop_ready", req_ready[0], 1);
        tick();
        clear_in();
        chk("pushpop_outst", outstanding[0], 8);

        // Malformed requests: units 1 (two bits) and 2 (no bits).
        req_valid = 4'b0110; req_way[1] = 8'b0000_0110; req_way[2] = 8'h00;
        way_req_ready = '1;
        #1;
        chk("bad_ready", req_ready, 4'b0110);
        chk("bad_way_valid", way_req_valid, 0);
        chk("bad_err_early", err, 0);
        tick();
        clear_in();
        chk("bad_err", err, 1);
        chk("bad_err_unit", err_unit, 1);
        req_valid = 4'b1000; req_way[3] = 8'hFF;
        tick();
        clear_in();
        chk("bad_err3", err, 1);
        chk("bad_err_unit3", err_unit, 3);
        tick();
        chk("bad_err_clear", err, 0);
        chk("bad_outst", outstanding[0], 8);

        // Reset with pending ordering state, then a fresh request.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_outst", outstanding, 0);
        req_valid[0] = 1'b1; req_way[0] = 8'h01; way_req_ready[0] = 1'b1;
        #1;
        chk("rst2_ready", req_ready[0], 1);
        chk("rst2_way_valid", way_req_valid, 8'h01);
        chk("rst2_way_unit", way_req_unit[0], 0);
        tick();
        clear_in();
        chk("rst2_outst1", outstanding[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
